// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU: memory sequencer states,
// the reset PC default and PC alignment.
package cpu_pkg;

  typedef enum logic [2:0] {
    IFETCH,
    IWAIT,
    EXEC,
    DWAIT,
    DCOMMIT,
    HALTED
  } seq_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Instructions are word aligned; the CPU may hand over an unaligned target.
  function automatic logic [31:0] align_pc(input logic [31:0] target);
    return target & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/mem_sequencer.sv
// Sequences instruction fetch and data access over one single-port synchronous
// memory; raises E whenever the CPU datapath must not commit.
module mem_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_next_pc,
  input  logic [29:0] cpu_daddr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_we,
  input  logic        cpu_re,
  input  logic        cpu_halt,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] rdata,
  output logic        E,
  output logic        mem_en,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  seq_state_e state;

  // NOTE: reset is synchronous, so it appears only inside the clocked branch;
  // sequential state uses non-blocking assignments so every register sees
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IFETCH;
      pc    <= RESET_PC;
      instr <= '0;
      rdata <= '0;
    end else begin
      unique case (state)
        IFETCH: state <= IWAIT;
        IWAIT: begin
          instr <= mem_rdata;
          state <= EXEC;
        end
        EXEC: begin
          // Halt wins over any memory request; a store wins over a load.
          if (cpu_halt) begin
            state <= HALTED;
          end else if (cpu_re && !cpu_we) begin
            state <= DWAIT;
          end else begin
            pc    <= align_pc(cpu_next_pc);
            state <= IFETCH;
          end
        end
        DWAIT: begin
          rdata <= mem_rdata;
          state <= DCOMMIT;
        end
        DCOMMIT: begin
          pc    <= align_pc(cpu_next_pc);
          state <= IFETCH;
        end
        HALTED:  state <= HALTED;
        default: state <= IFETCH;
      endcase
    end
  end

  // NOTE: every output gets a default before the case, so no path can infer a latch.
  always_comb begin
    E         = 1'b1;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!rst) begin
      unique case (state)
        IFETCH: begin
          mem_en   = 1'b1;
          mem_addr = pc[31:2];
        end
        EXEC: begin
          if (!cpu_halt) begin
            if (cpu_we) begin
              mem_en    = 1'b1;
              mem_we    = 1'b1;
              mem_addr  = cpu_daddr;
              mem_wdata = cpu_wdata;
              E         = 1'b0;
            end else if (cpu_re) begin
              mem_en   = 1'b1;
              mem_addr = cpu_daddr;
            end else begin
              E = 1'b0;
            end
          end
        end
        DCOMMIT: E = 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_sequencer.sv
// Self-checking bench: instruction-level reference model with a shadow memory,
// directed scenarios followed by randomized instruction streams.
module tb_mem_sequencer;

  typedef enum {K_ALU, K_STORE, K_LOAD, K_BOTH, K_HALT} kind_e;

  localparam logic [31:0] RST_PC    = 32'h0000_0000;
  localparam int          MEM_WORDS = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cpu_next_pc = '0;
  logic [29:0] cpu_daddr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_we = 1'b0, cpu_re = 1'b0, cpu_halt = 1'b0;
  logic [31:0] instr, pc, rdata;
  logic        E, mem_en, mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  // Memory fixture (wraps every MEM_WORDS words) with a preload port.
  logic [31:0] fx_mem [MEM_WORDS];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;

  // Reference model state.
  logic [31:0] shadow [MEM_WORDS];
  logic [31:0] m_pc, m_instr, m_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_sequencer dut (
    .clk(clk), .rst(rst),
    .cpu_next_pc(cpu_next_pc), .cpu_daddr(cpu_daddr), .cpu_wdata(cpu_wdata),
    .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_halt(cpu_halt),
    .instr(instr), .pc(pc), .rdata(rdata), .E(E),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (pl_en) fx_mem[pl_addr] <= pl_data;
    else if (mem_en) begin
      if (mem_we) fx_mem[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= fx_mem[mem_addr[7:0]];
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic check_bus(input string tag, input bit e, input bit en, input bit we,
                           input logic [29:0] a, input logic [31:0] wd);
    check({tag, ".E"},         32'(E),        32'(e));
    check({tag, ".mem_en"},    32'(mem_en),   32'(en));
    check({tag, ".mem_we"},    32'(mem_we),   32'(we));
    check({tag, ".mem_addr"},  32'(mem_addr), 32'(a));
    check({tag, ".mem_wdata"}, mem_wdata,     wd);
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".pc"},    pc,    m_pc);
    check({tag, ".instr"}, instr, m_instr);
    check({tag, ".rdata"}, rdata, m_rdata);
  endtask

  // Start a new cycle: release reset and scramble the CPU inputs, which the
  // sequencer must ignore unless the scenario sets them deliberately.
  task automatic cycle_begin();
    @(negedge clk);
    rst         = 1'b0;
    cpu_next_pc = $urandom;
    cpu_daddr   = 30'($urandom);
    cpu_wdata   = $urandom;
    cpu_we      = 1'($urandom);
    cpu_re      = 1'($urandom);
    cpu_halt    = 1'($urandom);
  endtask

  task automatic do_reset();
    cycle_begin();
    rst      = 1'b1;
    cpu_halt = 1'b1;
    #1;
    check_bus("reset", 1'b1, 1'b0, 1'b0, '0, '0);
    m_pc    = RST_PC;
    m_instr = '0;
    m_rdata = '0;
  endtask

  task automatic do_instr(input kind_e kind, input logic [31:0] npc, input logic [29:0] daddr,
                          input logic [31:0] wdata, input bit abort_dwait);
    cycle_begin();
    #1;
    check_regs("ifetch");
    check_bus("ifetch", 1'b1, 1'b1, 1'b0, m_pc[31:2], '0);

    cycle_begin();
    #1;
    check_regs("iwait");
    check_bus("iwait", 1'b1, 1'b0, 1'b0, '0, '0);
    m_instr = shadow[m_pc[9:2]];

    cycle_begin();
    cpu_next_pc = npc;
    cpu_daddr   = daddr;
    cpu_wdata   = wdata;
    cpu_halt    = (kind == K_HALT);
    if (kind != K_HALT) begin
      cpu_we = (kind == K_STORE) || (kind == K_BOTH);
      cpu_re = (kind == K_LOAD)  || (kind == K_BOTH);
    end
    #1;
    check_regs("exec");
    case (kind)
      K_ALU: begin
        check_bus("exec_alu", 1'b0, 1'b0, 1'b0, '0, '0);
        m_pc = {npc[31:2], 2'b00};
      end
      K_STORE, K_BOTH: begin
        check_bus("exec_store", 1'b0, 1'b1, 1'b1, daddr, wdata);
        shadow[daddr[7:0]] = wdata;
        m_pc = {npc[31:2], 2'b00};
        @(posedge clk);
        #1;
        check("store_mem", fx_mem[daddr[7:0]], wdata);
      end
      K_LOAD: begin
        check_bus("exec_load", 1'b1, 1'b1, 1'b0, daddr, '0);
        cycle_begin();
        if (abort_dwait) rst = 1'b1;
        #1;
        check_regs("dwait");
        check_bus("dwait", 1'b1, 1'b0, 1'b0, '0, '0);
        if (abort_dwait) begin
          m_pc    = RST_PC;
          m_instr = '0;
          m_rdata = '0;
        end else begin
          m_rdata = shadow[daddr[7:0]];
          cycle_begin();
          cpu_next_pc = npc;
          #1;
          check_regs("dcommit");
          check_bus("dcommit", 1'b0, 1'b0, 1'b0, '0, '0);
          m_pc = {npc[31:2], 2'b00};
        end
      end
      K_HALT: begin
        check_bus("exec_halt", 1'b1, 1'b0, 1'b0, '0, '0);
        repeat (20) begin
          cycle_begin();
          #1;
          check_regs("halted");
          check_bus("halted", 1'b1, 1'b0, 1'b0, '0, '0);
        end
        do_reset();
      end
      default: ;
    endcase
  endtask

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) begin
      @(negedge clk);
      pl_en   = 1'b1;
      pl_addr = 8'(i);
      pl_data = (i == 0) ? 32'h2001_0005 : $urandom;
      shadow[i] = pl_data;
    end
    @(negedge clk);
    pl_en = 1'b0;

    do_reset();
    do_instr(K_ALU,   32'h0000_0004, 30'h0,  32'h0,         1'b0);
    do_instr(K_STORE, 32'h0000_0008, 30'h10, 32'hDEAD_BEEF, 1'b0);
    do_instr(K_LOAD,  32'h0000_000C, 30'h10, 32'h0,         1'b0);
    do_instr(K_BOTH,  32'h0000_0013, 30'h11, 32'h1234_5678, 1'b0);
    do_instr(K_LOAD,  32'h0000_0014, 30'h10, 32'h0,         1'b1);
    do_instr(K_ALU,   32'hFFFF_FFFF, 30'h0,  32'h0,         1'b0);
    do_instr(K_ALU,   32'h0000_0020, 30'h0,  32'h0,         1'b0);
    do_instr(K_HALT,  32'h0000_0040, 30'h5,  32'h0,         1'b0);

    for (int n = 0; n < 300; n++) begin
      int    r;
      kind_e k;
      r = int'($urandom_range(0, 99));
      if (r < 30)      k = K_ALU;
      else if (r < 50) k = K_STORE;
      else if (r < 80) k = K_LOAD;
      else if (r < 95) k = K_BOTH;
      else             k = K_HALT;
      do_instr(k, $urandom, 30'($urandom), $urandom, ($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
